// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART receive FIFO.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;
    localparam int unsigned UART_DEPTH  = 16;

    // Ceiling log2, used to size pointers from the entry count.
    function automatic int unsigned log2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W storage array: synchronous write, asynchronous read, no reset.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = UART_DATA_W,
    parameter int unsigned DEPTH  = UART_DEPTH,
    localparam int unsigned AW    = log2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with write-accept pulse and sticky overrun flag.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = UART_DATA_W,
    parameter int unsigned DEPTH  = UART_DEPTH,
    localparam int unsigned AW    = log2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r_data,
    input  logic [DATA_W-1:0] datain,
    input  logic              rd_en,
    input  logic              clr_ovr,
    output logic [DATA_W-1:0] dataout,
    output logic              valid,
    output logic              ready,
    output logic              full,
    output logic [AW:0]       count,
    output logic              overrun
);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              ready_q, ready_d;
    logic              overrun_q, overrun_d;
    logic              is_empty, is_full;
    logic              wr_accept, rd_accept, mem_we;
    logic [DATA_W-1:0] mem_rdata;

    // Occupancy flags come from the counter so that wrapped pointers never alias full/empty.
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == (AW+1)'(DEPTH));

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_accept = rd_en && !is_empty;
        wr_accept = r_data && (!is_full || rd_accept);
        ready_d   = wr_accept;
        // A drop sets the flag even when a clear arrives in the same cycle.
        overrun_d = (r_data && !wr_accept) || (overrun_q && !clr_ovr);

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage is not reset; a write issued during reset must not land in it.
    assign mem_we = wr_accept && !rst;

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (datain),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    assign valid   = !is_empty;
    assign full    = is_full;
    assign count   = count_q;
    assign ready   = ready_q;
    assign overrun = overrun_q;
    assign dataout = is_empty ? '0 : mem_rdata;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DATA_W=8, DEPTH=16).
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic       r_data;
    logic [7:0] datain;
    logic       rd_en;
    logic       clr_ovr;
    logic [7:0] dataout;
    logic       valid;
    logic       ready;
    logic       full;
    logic [4:0] count;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    uart_rx_fifo #(
        .DATA_W (8),
        .DEPTH  (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .r_data  (r_data),
        .datain  (datain),
        .rd_en   (rd_en),
        .clr_ovr (clr_ovr),
        .dataout (dataout),
        .valid   (valid),
        .ready   (ready),
        .full    (full),
        .count   (count),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs, then settle 1 time unit past the rising edge.
    task automatic step(input logic w, input logic [7:0] d, input logic rd,
                        input logic clr, input logic rs);
        r_data  = w;
        datain  = d;
        rd_en   = rd;
        clr_ovr = clr;
        rst     = rs;
        @(posedge clk);
        #1;
        r_data  = 1'b0;
        rd_en   = 1'b0;
        clr_ovr = 1'b0;
        rst     = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        checks++; if (dataout !== 8'h00) begin errors++; $display("FAIL reset_dataout: got %h want 00", dataout); end
    endtask

    task automatic test_single_write();
        step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", valid); end
        checks++; if (dataout !== 8'h41) begin errors++; $display("FAIL single_dataout: got %h want 41", dataout); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count: got %0d want 1", count); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", ready); end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL single_ready_drop: got %b want 0", ready); end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b want 0", valid); end
        checks++; if (dataout !== 8'h00) begin errors++; $display("FAIL single_pop_dataout: got %h want 00", dataout); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_pop_count: got %0d want 0", count); end
    endtask

    task automatic test_fill_overrun();
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            checks++; if (count !== 5'(i)) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i); end
            checks++; if (ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d]: got %b want 1", i, ready); end
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", full); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fill_overrun_pre: got %b want 0", overrun); end
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL drop_overrun: got %b want 1", overrun); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL drop_ready: got %b want 0", ready); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL drop_count: got %0d want 16", count); end
        for (int i = 1; i <= 16; i++) begin
            checks++; if (dataout !== 8'(i)) begin errors++; $display("FAIL drain_data[%0d]: got %h want %h", i, dataout, 8'(i)); end
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            checks++; if (count !== 5'(16 - i)) begin errors++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, count, 16 - i); end
        end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", valid); end
        checks++; if (dataout !== 8'h00) begin errors++; $display("FAIL drain_dataout: got %h want 00", dataout); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL sticky_overrun: got %b want 1", overrun); end
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL clr_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_full_rw();
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_rw_count: got %0d want 16", count); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL full_rw_overrun: got %b want 0", overrun); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL full_rw_ready: got %b want 1", ready); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_rw_full: got %b want 1", full); end
        for (int i = 2; i <= 17; i++) begin
            logic [7:0] want;
            want = (i == 17) ? 8'hAA : 8'(i);
            checks++; if (dataout !== want) begin errors++; $display("FAIL full_rw_data[%0d]: got %h want %h", i, dataout, want); end
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL full_rw_empty: got %b want 0", valid); end
    endtask

    task automatic test_empty_rw();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL empty_rd_count: got %0d want 0", count); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL empty_rd_valid: got %b want 0", valid); end
        checks++; if (dataout !== 8'h00) begin errors++; $display("FAIL empty_rd_dataout: got %h want 00", dataout); end
        step(1'b1, 8'h7E, 1'b1, 1'b0, 1'b0);
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL empty_rw_count: got %0d want 1", count); end
        checks++; if (dataout !== 8'h7E) begin errors++; $display("FAIL empty_rw_dataout: got %h want 7e", dataout); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL empty_rw_ready: got %b want 1", ready); end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL empty_rw_pop: got %0d want 0", count); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_q[$];
        logic [7:0] wdata;
        logic       do_rd;
        logic       rd_ok;
        for (int i = 0; i < 40; i++) begin
            wdata = 8'((i * 7 + 3) & 8'hFF);
            do_rd = (i % 4) != 0;
            rd_ok = do_rd && (exp_q.size() > 0);
            if (rd_ok) begin
                checks++; if (dataout !== exp_q[0]) begin errors++; $display("FAIL wrap_data[%0d]: got %h want %h", i, dataout, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            if (exp_q.size() < 16 || rd_ok) exp_q.push_back(wdata);
            step(1'b1, wdata, do_rd, 1'b0, 1'b0);
            checks++; if (count !== 5'(exp_q.size())) begin errors++; $display("FAIL wrap_count[%0d]: got %0d want %0d", i, count, exp_q.size()); end
        end
        while (exp_q.size() > 0) begin
            checks++; if (dataout !== exp_q[0]) begin errors++; $display("FAIL wrap_drain: got %h want %h", dataout, exp_q[0]); end
            void'(exp_q.pop_front());
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL wrap_final_count: got %0d want 0", count); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        checks++; if (count !== 5'd5) begin errors++; $display("FAIL mid_pre_count: got %0d want 5", count); end
        step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL mid_rst_count: got %0d want 0", count); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_rst_overrun: got %b want 0", overrun); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b want 0", ready); end
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        checks++; if (dataout !== 8'h21) begin errors++; $display("FAIL mid_refill_head: got %h want 21", dataout); end
        step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_first_drop: got %b want 1", overrun); end
        step(1'b1, 8'h67, 1'b0, 1'b1, 1'b0);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins: got %b want 1", overrun); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovr_count: got %0d want 16", count); end
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", overrun); end
        step(1'b1, 8'h68, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_rst: got %b want 0", overrun); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_rst: got %b want 0", full); end
        checks++; if (dataout !== 8'h00) begin errors++; $display("FAIL dataout_rst: got %h want 00", dataout); end
    endtask

    initial begin
        rst     = 1'b1;
        r_data  = 1'b0;
        datain  = 8'h00;
        rd_en   = 1'b0;
        clr_ovr = 1'b0;
        test_reset();
        test_single_write();
        test_fill_overrun();
        test_full_rw();
        test_empty_rw();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
